down_counter_reload: RTL and testbench

//  Loadable down counter/timer. Counterpart to the team's free-running up counter.

---
 rtl/basic_blocks_pkg.sv | 14 +
 rtl/prescaler_tick.sv | 49 ++++
 rtl/down_counter_reload.sv | 86 ++++++++
 tb/tb_down_counter_reload.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/basic_blocks_pkg.sv
// Shared definitions for the Basic_Blocks counter/timer family.
// Mode encodings and a prescaler width helper.
package basic_blocks_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  function automatic int unsigned presc_width(
    input int unsigned p
  );
    return (p > 1) ? $clog2(p) : 1;
  endfunction

endpackage

// File: rtl/prescaler_tick.sv
// Divides enabled increments down to one tick every PRESCALE incs.
// PRESCALE=1 passes inc straight through with no state.
module prescaler_tick
  import basic_blocks_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tick
);

  generate
    if (PRESCALE <= 1) begin : g_bypass
      logic unused_ok;
      assign unused_ok = ^{clk, reset, clr};
      assign tick = inc;
    end else begin : g_count
      localparam int unsigned W = presc_width(PRESCALE);
      localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

      logic [W-1:0] cnt_q;
      logic [W-1:0] cnt_d;

      always_comb begin
        tick  = inc & (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (tick) begin
          cnt_d = '0;
        end else if (inc) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/down_counter_reload.sv
// Loadable down counter/timer with terminal-count pulse.
// One-shot or auto-reload; Q never underflows past 0.
module down_counter_reload
  import basic_blocks_pkg::*;
#(
  parameter int unsigned Bits     = 4,
  parameter int unsigned PRESCALE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            load,
  input  logic [Bits-1:0] load_val,
  input  logic            periodic,
  output logic [Bits-1:0] Q,
  output logic            zero,
  output logic            tc_pulse,
  output logic            busy
);

  localparam logic [Bits-1:0] ONE = Bits'(1);

  logic [Bits-1:0] q_q;
  logic [Bits-1:0] q_d;
  logic [Bits-1:0] reload_q;
  logic [Bits-1:0] reload_d;
  logic            busy_q;
  logic            busy_d;
  logic            tc_q;
  logic            tc_d;
  logic            tick;

  prescaler_tick #(
    .PRESCALE(PRESCALE)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .clr  (load),
    .inc  (en & busy_q),
    .tick (tick)
  );

  always_comb begin
    q_d      = q_q;
    reload_d = reload_q;
    busy_d   = busy_q;
    tc_d     = 1'b0;
    if (load) begin
      q_d      = load_val;
      reload_d = load_val;
      busy_d   = |load_val;
    end else if (tick) begin
      if (q_q == ONE) begin
        tc_d = 1'b1;
        if (periodic == MODE_PERIODIC) begin
          q_d = reload_q;
        end else begin
          q_d    = '0;
          busy_d = 1'b0;
        end
      end else begin
        q_d = q_q - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q      <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      q_q      <= q_d;
      reload_q <= reload_d;
      busy_q   <= busy_d;
      tc_q     <= tc_d;
    end
  end

  assign Q        = q_q;
  assign zero     = (q_q == '0);
  assign tc_pulse = tc_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed scoreboard bench for down_counter_reload.
// Two instances: PRESCALE=1 (A) and PRESCALE=3 (B).
module tb_down_counter_reload;

  localparam bit A = 1'b0;
  localparam bit B = 1'b1;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       periodic;

  logic [3:0] q_a, q_b;
  logic       zero_a, zero_b;
  logic       tc_a, tc_b;
  logic       busy_a, busy_b;

  typedef struct {
    bit         which;
    logic [3:0] q;
    logic       tc;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  down_counter_reload #(.Bits(4), .PRESCALE(1)) dut_a (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .periodic(periodic),
    .Q       (q_a),
    .zero    (zero_a),
    .tc_pulse(tc_a),
    .busy    (busy_a)
  );

  down_counter_reload #(.Bits(4), .PRESCALE(3)) dut_b (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .load_val(load_val),
    .periodic(periodic),
    .Q       (q_b),
    .zero    (zero_b),
    .tc_pulse(tc_b),
    .busy    (busy_b)
  );

  task automatic check_one(input string tag, input string fld,
                           input logic [3:0] got, input logic [3:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s.%s: got %0h expected %0h", tag, fld, got, want);
    end
  endtask

  task automatic compare();
    exp_t x;
    logic [3:0] q;
    logic       z, t, b;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: got empty queue expected entry");
      return;
    end
    x = sb.pop_front();
    q = (x.which == B) ? q_b    : q_a;
    z = (x.which == B) ? zero_b : zero_a;
    t = (x.which == B) ? tc_b   : tc_a;
    b = (x.which == B) ? busy_b : busy_a;
    check_one(x.tag, "Q",    q,         x.q);
    check_one(x.tag, "tc",   {3'b0, t}, {3'b0, x.tc});
    check_one(x.tag, "busy", {3'b0, b}, {3'b0, x.busy});
    check_one(x.tag, "zero", {3'b0, z}, {3'b0, (x.q == 4'd0)});
  endtask

  task automatic step(input logic r, input logic e, input logic l,
                      input logic [3:0] v, input logic p, input bit w,
                      input logic [3:0] eq, input logic etc,
                      input logic ebusy, input string tag);
    exp_t x;
    reset    = r;
    en       = e;
    load     = l;
    load_val = v;
    periodic = p;
    x.which = w;
    x.q     = eq;
    x.tc    = etc;
    x.busy  = ebusy;
    x.tag   = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0;
    load_val = 4'd0; periodic = 1'b0;

    step(1, 0, 0, 0, 0, A, 0, 0, 0, "reset_a");
    step(1, 0, 0, 0, 0, B, 0, 0, 0, "reset_b");

    // reset mid-count
    step(0, 1, 1, 5, 0, A, 5, 0, 1, "rst_load5");
    step(1, 1, 0, 0, 0, A, 0, 0, 0, "rst_mid");
    step(0, 1, 0, 0, 0, A, 0, 0, 0, "rst_after");

    // one-shot, load 3
    step(0, 1, 1, 3, 0, A, 3, 0, 1, "os_load");
    step(0, 1, 0, 0, 0, A, 2, 0, 1, "os_2");
    step(0, 1, 0, 0, 0, A, 1, 0, 1, "os_1");
    step(0, 1, 0, 0, 0, A, 0, 1, 0, "os_tc");
    step(0, 1, 0, 0, 0, A, 0, 0, 0, "os_stop");
    step(0, 1, 0, 0, 0, A, 0, 0, 0, "os_stop2");

    // periodic, load 4
    step(0, 1, 1, 4, 1, A, 4, 0, 1, "per_load");
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, 0, 1, A, 3, 0, 1, "per_3");
      step(0, 1, 0, 0, 1, A, 2, 0, 1, "per_2");
      step(0, 1, 0, 0, 1, A, 1, 0, 1, "per_1");
      step(0, 1, 0, 0, 1, A, 4, 1, 1, "per_wrap");
    end

    // en low freezes, resume
    step(0, 0, 0, 0, 1, A, 4, 0, 1, "hold_0");
    step(0, 0, 0, 0, 1, A, 4, 0, 1, "hold_1");
    step(0, 1, 0, 0, 1, A, 3, 0, 1, "resume");

    // periodic dropped mid-run takes effect at terminal
    step(0, 1, 1, 2, 1, A, 2, 0, 1, "mode_load");
    step(0, 1, 0, 0, 0, A, 1, 0, 1, "mode_1");
    step(0, 1, 0, 0, 0, A, 0, 1, 0, "mode_tc");

    // load on terminal tick wins
    step(0, 1, 1, 2, 1, A, 2, 0, 1, "lt_load");
    step(0, 1, 0, 0, 1, A, 1, 0, 1, "lt_1");
    step(0, 1, 1, 7, 1, A, 7, 0, 1, "lt_reload7");
    step(0, 1, 0, 0, 1, A, 6, 0, 1, "lt_6");

    // load 0 stays idle
    step(0, 1, 1, 0, 0, A, 0, 0, 0, "z_load");
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0, A, 0, 0, 0, "z_idle");
    end

    // full-range load
    step(0, 1, 1, 15, 0, A, 15, 0, 1, "f_load");
    for (int i = 14; i >= 1; i--) begin
      step(0, 1, 0, 0, 0, A, 4'(i), 0, 1, "f_cnt");
    end
    step(0, 1, 0, 0, 0, A, 0, 1, 0, "f_tc");
    step(0, 1, 0, 0, 0, A, 0, 0, 0, "f_done");

    // PRESCALE=3, load 2, en 1,0,1,1,1,1,1
    step(1, 0, 0, 0, 0, B, 0, 0, 0, "p3_rst");
    step(0, 1, 1, 2, 0, B, 2, 0, 1, "p3_load");
    step(0, 1, 0, 0, 0, B, 2, 0, 1, "p3_e1");
    step(0, 0, 0, 0, 0, B, 2, 0, 1, "p3_e0");
    step(0, 1, 0, 0, 0, B, 2, 0, 1, "p3_e2");
    step(0, 1, 0, 0, 0, B, 1, 0, 1, "p3_dec");
    step(0, 1, 0, 0, 0, B, 1, 0, 1, "p3_e4");
    step(0, 1, 0, 0, 0, B, 1, 0, 1, "p3_e5");
    step(0, 1, 0, 0, 0, B, 0, 1, 0, "p3_tc");
    step(0, 1, 0, 0, 0, B, 0, 0, 0, "p3_stop");

    // PRESCALE=3 periodic, reload 1: tc every 3 enabled cycles
    step(0, 1, 1, 1, 1, B, 1, 0, 1, "p3p_load");
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, 0, 1, B, 1, 0, 1, "p3p_a");
      step(0, 1, 0, 0, 1, B, 1, 0, 1, "p3p_b");
      step(0, 1, 0, 0, 1, B, 1, 1, 1, "p3p_tc");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
